// File: rtl/id_control_pipe_pkg.sv
// Shared constants for the ID control stage: MIPS-I opcode/funct codes, one-hot mux
// bit positions, the control bundle type and the delay-slot FSM encoding.
package id_control_pipe_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'h00, OP_REGIMM = 6'h01, OP_J    = 6'h02, OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04, OP_BNE    = 6'h05, OP_BLEZ = 6'h06, OP_BGTZ  = 6'h07;
  localparam logic [5:0] OP_ADDI    = 6'h08, OP_ADDIU  = 6'h09, OP_SLTI = 6'h0a, OP_SLTIU = 6'h0b;
  localparam logic [5:0] OP_ANDI    = 6'h0c, OP_ORI    = 6'h0d, OP_XORI = 6'h0e, OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LB      = 6'h20, OP_LH     = 6'h21, OP_LW   = 6'h23, OP_LBU   = 6'h24;
  localparam logic [5:0] OP_LHU     = 6'h25, OP_SB     = 6'h28, OP_SH   = 6'h29, OP_SW    = 6'h2b;

  localparam logic [5:0] F_SLL  = 6'h00, F_SRL  = 6'h02, F_SRA   = 6'h03, F_SLLV  = 6'h04;
  localparam logic [5:0] F_SRLV = 6'h06, F_SRAV = 6'h07, F_JR    = 6'h08, F_JALR  = 6'h09;
  localparam logic [5:0] F_SYSCALL = 6'h0c, F_BREAK = 6'h0d;
  localparam logic [5:0] F_MFHI = 6'h10, F_MTHI = 6'h11, F_MFLO  = 6'h12, F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT = 6'h18, F_MULTU = 6'h19, F_DIV  = 6'h1a, F_DIVU  = 6'h1b;
  localparam logic [5:0] F_ADD  = 6'h20, F_ADDU = 6'h21, F_SUB   = 6'h22, F_SUBU  = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24, F_OR   = 6'h25, F_XOR   = 6'h26, F_NOR   = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2a, F_SLTU = 6'h2b;

  // Bit positions inside each one-hot select (bit 0 is the first listed source)
  localparam logic [2:0] PCV_PC4 = 3'd0, PCV_ALU = 3'd1, PCV_INDEX = 3'd2, PCV_TEMP = 3'd3, PCV_SLOT = 3'd4;
  localparam logic [2:0] S1_RS = 3'd0, S1_SA = 3'd1, S1_PC = 3'd2;
  localparam logic [2:0] S2_RT = 3'd0, S2_IMM = 3'd1, S2_HI = 3'd2, S2_LO = 3'd3;
  localparam logic [2:0] WD_ALU = 3'd0, WD_DRAM = 3'd1, WD_PC8 = 3'd2;
  localparam logic [2:0] WA_RD = 3'd0, WA_RT = 3'd1, WA_31 = 3'd2;

  typedef struct packed {
    logic [4:0] pc_value_mux;
    logic [2:0] alu_src1_mux;
    logic [3:0] alu_src2_mux;
    logic [2:0] rf_wdata_mux;
    logic [2:0] rf_waddr_mux;
    logic       rf_wen;
    logic       dram_en;
    logic       dram_wen;
    logic       low_wen;
    logic       high_wen;
    logic       temp_wen;
  } ctl_t;

  typedef enum logic [0:0] {DS_SEQ = 1'b0, DS_SLOT = 1'b1} ds_state_t;

endpackage

// File: rtl/id_decode_comb.sv
// Pure combinational MIPS-I decoder: instruction word to one-hot control bundle plus
// classification flags (branch/jump, MDU op, HI/LO user, reserved).
module id_decode_comb
  import id_control_pipe_pkg::*;
(
  input  logic [31:0] inst,
  output ctl_t        ctl,
  output logic        is_branch,
  output logic        is_mdu,
  output logic        is_div,
  output logic        uses_hilo,
  output logic        is_ri
);

  logic [5:0] opcode;
  logic [5:0] funct;
  logic [4:0] rt;
  logic [2:0] pcv_sel, src1_sel, src2_sel, wdata_sel, waddr_sel;
  logic       unused_inst_bits;

  assign opcode = inst[31:26];
  assign funct  = inst[5:0];
  assign rt     = inst[20:16];
  assign unused_inst_bits = ^{inst[25:21], inst[15:6]};

  always_comb begin
    pcv_sel   = PCV_PC4;
    src1_sel  = S1_RS;
    src2_sel  = S2_RT;
    wdata_sel = WD_ALU;
    waddr_sel = WA_RD;
    ctl       = '0;
    is_branch = 1'b0;
    is_mdu    = 1'b0;
    is_div    = 1'b0;
    uses_hilo = 1'b0;
    is_ri     = 1'b0;
    case (opcode)
      OP_SPECIAL: begin
        case (funct)
          F_SLL, F_SRL, F_SRA: begin src1_sel = S1_SA; ctl.rf_wen = 1'b1; end
          F_SLLV, F_SRLV, F_SRAV, F_ADD, F_ADDU, F_SUB, F_SUBU,
          F_AND, F_OR, F_XOR, F_NOR, F_SLT, F_SLTU: ctl.rf_wen = 1'b1;
          F_JR:    begin pcv_sel = PCV_ALU; is_branch = 1'b1; end
          F_JALR:  begin pcv_sel = PCV_ALU; wdata_sel = WD_PC8; ctl.rf_wen = 1'b1; is_branch = 1'b1; end
          F_SYSCALL, F_BREAK: begin end
          F_MFHI:  begin src2_sel = S2_HI; ctl.rf_wen = 1'b1; uses_hilo = 1'b1; end
          F_MFLO:  begin src2_sel = S2_LO; ctl.rf_wen = 1'b1; uses_hilo = 1'b1; end
          F_MTHI:  begin ctl.high_wen = 1'b1; uses_hilo = 1'b1; end
          F_MTLO:  begin ctl.low_wen = 1'b1; uses_hilo = 1'b1; end
          F_MULT, F_MULTU, F_DIV, F_DIVU: begin
            ctl.low_wen  = 1'b1;
            ctl.high_wen = 1'b1;
            is_mdu       = 1'b1;
            uses_hilo    = 1'b1;
            is_div       = funct[1];
          end
          default: is_ri = 1'b1;
        endcase
      end
      // Only BLTZ/BGEZ/BLTZAL/BGEZAL exist under REGIMM; rt[4] selects the linking forms
      OP_REGIMM: begin
        if (rt[3:1] == 3'b000) begin
          pcv_sel = PCV_TEMP; src1_sel = S1_PC; src2_sel = S2_IMM;
          ctl.temp_wen = 1'b1; is_branch = 1'b1;
          if (rt[4]) begin ctl.rf_wen = 1'b1; wdata_sel = WD_PC8; waddr_sel = WA_31; end
        end else begin
          is_ri = 1'b1;
        end
      end
      OP_J:   begin pcv_sel = PCV_INDEX; is_branch = 1'b1; end
      OP_JAL: begin
        pcv_sel = PCV_INDEX; is_branch = 1'b1;
        ctl.rf_wen = 1'b1; wdata_sel = WD_PC8; waddr_sel = WA_31;
      end
      // Branch target (PC-relative) is formed by the ALU and parked in temp
      OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: begin
        pcv_sel = PCV_TEMP; src1_sel = S1_PC; src2_sel = S2_IMM;
        ctl.temp_wen = 1'b1; is_branch = 1'b1;
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
        src2_sel = S2_IMM; waddr_sel = WA_RT; ctl.rf_wen = 1'b1;
      end
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
        src2_sel = S2_IMM; waddr_sel = WA_RT; wdata_sel = WD_DRAM;
        ctl.rf_wen = 1'b1; ctl.dram_en = 1'b1;
      end
      OP_SB, OP_SH, OP_SW: begin
        src2_sel = S2_IMM; ctl.dram_en = 1'b1; ctl.dram_wen = 1'b1;
      end
      default: is_ri = 1'b1;
    endcase
    ctl.pc_value_mux = 5'd1 << pcv_sel;
    ctl.alu_src1_mux = 3'd1 << src1_sel;
    ctl.alu_src2_mux = 4'd1 << src2_sel;
    ctl.rf_wdata_mux = 3'd1 << wdata_sel;
    ctl.rf_waddr_mux = 3'd1 << waddr_sel;
  end

endmodule

// File: rtl/id_control_pipe.sv
// Registered decode-control stage: valid/ready output register around id_decode_comb,
// with delay-slot tracking, HI/LO busy interlock for MULT/DIV and reserved-op squashing.
module id_control_pipe
  import id_control_pipe_pkg::*;
#(
  parameter int unsigned MUL_LATENCY = 5,
  parameter int unsigned DIV_LATENCY = 12,
  parameter bit          ENABLE_EXC  = 1'b1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] inst,
  input  logic [31:0] in_pc,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [4:0]  ctl_pcValue_mux,
  output logic [2:0]  ctl_aluSrc1_mux,
  output logic [3:0]  ctl_aluSrc2_mux,
  output logic [2:0]  ctl_rfWriteData_mux,
  output logic [2:0]  ctl_rfWriteAddr_mux,
  output logic        ctl_rf_wen,
  output logic        ctl_dataRam_en,
  output logic        ctl_dataRam_wen,
  output logic        ctl_low_wen,
  output logic        ctl_high_wen,
  output logic        ctl_temp_wen,
  output logic        in_delay_slot,
  output logic        exc_ri,
  output logic        hilo_busy
);

  localparam logic [3:0] MUL_LAT = 4'(MUL_LATENCY);
  localparam logic [3:0] DIV_LAT = 4'(DIV_LATENCY);

  ctl_t       dec_ctl, eff_ctl, ctl_reg;
  logic       dec_branch, dec_mdu, dec_div, dec_hilo, dec_ri;
  logic       ri_eff, hilo_stall, accept, consume;
  logic [3:0] lat_in, lat_reg, busy_cnt_reg, busy_cnt_next;
  logic       out_valid_reg, slot_reg, exc_reg;
  logic [31:0] out_pc_reg;
  ds_state_t  state_reg, state_next;

  id_decode_comb u_decode (
    .inst      (inst),
    .ctl       (dec_ctl),
    .is_branch (dec_branch),
    .is_mdu    (dec_mdu),
    .is_div    (dec_div),
    .uses_hilo (dec_hilo),
    .is_ri     (dec_ri)
  );

  assign ri_eff = ENABLE_EXC & dec_ri;

  // A reserved op travels down the pipe only to raise exc_ri; it must not touch state
  always_comb begin
    eff_ctl = dec_ctl;
    if (ri_eff) begin
      eff_ctl.pc_value_mux = '0;
      eff_ctl.pc_value_mux[PCV_PC4] = 1'b1;
      eff_ctl.rf_wen   = 1'b0;
      eff_ctl.dram_en  = 1'b0;
      eff_ctl.dram_wen = 1'b0;
      eff_ctl.low_wen  = 1'b0;
      eff_ctl.high_wen = 1'b0;
      eff_ctl.temp_wen = 1'b0;
    end
  end

  assign hilo_busy  = (busy_cnt_reg != 4'd0);
  assign hilo_stall = hilo_busy & dec_hilo;
  assign in_ready   = (~out_valid_reg | out_ready) & ~hilo_stall & ~flush;
  assign accept     = in_valid & in_ready;
  assign consume    = out_valid_reg & out_ready;
  assign lat_in     = (dec_mdu & ~ri_eff) ? (dec_div ? DIV_LAT : MUL_LAT) : 4'd0;

  // The counter starts only when EX actually takes the MDU op, not when it is decoded
  always_comb begin
    busy_cnt_next = busy_cnt_reg;
    if (consume && lat_reg != 4'd0)
      busy_cnt_next = lat_reg;
    else if (busy_cnt_reg != 4'd0)
      busy_cnt_next = busy_cnt_reg - 4'd1;
  end

  always_comb begin
    state_next = state_reg;
    if (flush)
      state_next = DS_SEQ;
    else if (accept)
      state_next = (dec_branch & ~ri_eff) ? DS_SLOT : DS_SEQ;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg <= DS_SEQ;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_valid_reg <= 1'b0;
      ctl_reg       <= '0;
      out_pc_reg    <= '0;
      slot_reg      <= 1'b0;
      exc_reg       <= 1'b0;
      lat_reg       <= '0;
      busy_cnt_reg  <= '0;
    end else begin
      if (flush)
        out_valid_reg <= 1'b0;
      else if (accept)
        out_valid_reg <= 1'b1;
      else if (out_ready)
        out_valid_reg <= 1'b0;
      if (accept) begin
        ctl_reg    <= eff_ctl;
        out_pc_reg <= in_pc;
        slot_reg   <= (state_reg == DS_SLOT);
        exc_reg    <= ri_eff;
        lat_reg    <= lat_in;
      end
      busy_cnt_reg <= busy_cnt_next;
    end
  end

  assign out_valid           = out_valid_reg;
  assign out_pc              = out_pc_reg;
  assign ctl_pcValue_mux     = ctl_reg.pc_value_mux;
  assign ctl_aluSrc1_mux     = ctl_reg.alu_src1_mux;
  assign ctl_aluSrc2_mux     = ctl_reg.alu_src2_mux;
  assign ctl_rfWriteData_mux = ctl_reg.rf_wdata_mux;
  assign ctl_rfWriteAddr_mux = ctl_reg.rf_waddr_mux;
  assign ctl_rf_wen          = ctl_reg.rf_wen;
  assign ctl_dataRam_en      = ctl_reg.dram_en;
  assign ctl_dataRam_wen     = ctl_reg.dram_wen;
  assign ctl_low_wen         = ctl_reg.low_wen;
  assign ctl_high_wen        = ctl_reg.high_wen;
  assign ctl_temp_wen        = ctl_reg.temp_wen;
  assign in_delay_slot       = slot_reg;
  assign exc_ri              = exc_reg;

endmodule

// File: tb/tb_id_control_pipe.sv
// Directed bench for id_control_pipe: handshake, HI/LO interlock, delay slots, flush,
// reserved-instruction squashing (both ENABLE_EXC builds) and async reset mid-stall.
module tb_id_control_pipe;

  localparam logic [31:0] I_ADDU  = 32'h00221821, I_MULT = 32'h00220018, I_MULTU = 32'h00220019;
  localparam logic [31:0] I_DIV   = 32'h0022001a, I_MFLO = 32'h00002012, I_BEQ   = 32'h10220001;
  localparam logic [31:0] I_SW    = 32'hAC220000, I_JAL  = 32'h0C000010, I_LW    = 32'h8C220000;
  localparam logic [31:0] I_J     = 32'h08000040, I_JR   = 32'h03e00008, I_RSV   = 32'hFC000000;
  localparam logic [31:0] I_RSVF  = 32'h00000001;

  logic        clk = 1'b0, resetn = 1'b1, in_valid = 1'b0, flush = 1'b0, out_ready = 1'b1;
  logic [31:0] inst = '0, in_pc = '0;
  logic        in_ready, out_valid;
  logic [31:0] out_pc;
  logic [4:0]  ctl_pcValue_mux;
  logic [2:0]  ctl_aluSrc1_mux, ctl_rfWriteData_mux, ctl_rfWriteAddr_mux;
  logic [3:0]  ctl_aluSrc2_mux;
  logic        ctl_rf_wen, ctl_dataRam_en, ctl_dataRam_wen, ctl_low_wen, ctl_high_wen, ctl_temp_wen;
  logic        in_delay_slot, exc_ri, hilo_busy;

  logic        unused_n_in_ready, unused_n_out_valid, exc_ri_n;
  logic [31:0] unused_n_out_pc;
  logic [4:0]  unused_n_pcv;
  logic [2:0]  unused_n_s1, unused_n_wd, unused_n_wa;
  logic [3:0]  unused_n_s2;
  logic        unused_n_rfw, unused_n_de, unused_n_dw, unused_n_lw, unused_n_hw, unused_n_tw;
  logic        unused_n_ds, unused_n_busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  id_control_pipe #(.MUL_LATENCY(5), .DIV_LATENCY(12), .ENABLE_EXC(1'b1)) dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready), .inst(inst),
    .in_pc(in_pc), .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .ctl_pcValue_mux(ctl_pcValue_mux), .ctl_aluSrc1_mux(ctl_aluSrc1_mux),
    .ctl_aluSrc2_mux(ctl_aluSrc2_mux), .ctl_rfWriteData_mux(ctl_rfWriteData_mux),
    .ctl_rfWriteAddr_mux(ctl_rfWriteAddr_mux), .ctl_rf_wen(ctl_rf_wen),
    .ctl_dataRam_en(ctl_dataRam_en), .ctl_dataRam_wen(ctl_dataRam_wen),
    .ctl_low_wen(ctl_low_wen), .ctl_high_wen(ctl_high_wen), .ctl_temp_wen(ctl_temp_wen),
    .in_delay_slot(in_delay_slot), .exc_ri(exc_ri), .hilo_busy(hilo_busy)
  );

  id_control_pipe #(.MUL_LATENCY(5), .DIV_LATENCY(12), .ENABLE_EXC(1'b0)) dut_noexc (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(unused_n_in_ready), .inst(inst),
    .in_pc(in_pc), .flush(flush), .out_valid(unused_n_out_valid), .out_ready(out_ready),
    .out_pc(unused_n_out_pc), .ctl_pcValue_mux(unused_n_pcv), .ctl_aluSrc1_mux(unused_n_s1),
    .ctl_aluSrc2_mux(unused_n_s2), .ctl_rfWriteData_mux(unused_n_wd),
    .ctl_rfWriteAddr_mux(unused_n_wa), .ctl_rf_wen(unused_n_rfw), .ctl_dataRam_en(unused_n_de),
    .ctl_dataRam_wen(unused_n_dw), .ctl_low_wen(unused_n_lw), .ctl_high_wen(unused_n_hw),
    .ctl_temp_wen(unused_n_tw), .in_delay_slot(unused_n_ds), .exc_ri(exc_ri_n),
    .hilo_busy(unused_n_busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] i, input logic [31:0] pc);
    in_valid = v;
    inst     = i;
    in_pc    = pc;
    #1;
  endtask

  task automatic test_reset();
    #2 resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", out_valid); end
    checks++; if (out_pc !== 32'h0) begin errors++; $display("FAIL rst_pc: got %h want 0", out_pc); end
    checks++; if ({ctl_pcValue_mux, ctl_aluSrc1_mux, ctl_aluSrc2_mux, ctl_rf_wen, ctl_temp_wen} !== 14'h0) begin
      errors++; $display("FAIL rst_ctl: got %b want 0", {ctl_pcValue_mux, ctl_aluSrc1_mux, ctl_aluSrc2_mux, ctl_rf_wen, ctl_temp_wen});
    end
    checks++; if ({in_delay_slot, exc_ri, hilo_busy} !== 3'b000) begin
      errors++; $display("FAIL rst_flags: got %b want 000", {in_delay_slot, exc_ri, hilo_busy});
    end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
    #2 resetn = 1'b1;
    tick();
  endtask

  task automatic test_addu();
    out_ready = 1'b1;
    drive(1'b1, I_ADDU, 32'h100);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL addu_in_ready: got %b want 1", in_ready); end
    tick();
    drive(1'b0, 32'h0, 32'h0);
    $display("txn addu pc=%h valid=%b", out_pc, out_valid);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL addu_valid: got %b want 1", out_valid); end
    checks++; if (out_pc !== 32'h100) begin errors++; $display("FAIL addu_pc: got %h want 100", out_pc); end
    checks++; if ({ctl_pcValue_mux, ctl_aluSrc1_mux, ctl_aluSrc2_mux, ctl_rfWriteData_mux, ctl_rfWriteAddr_mux} !== 18'b00001_001_0001_001_001) begin
      errors++; $display("FAIL addu_mux: got %b want 000010010001001001",
        {ctl_pcValue_mux, ctl_aluSrc1_mux, ctl_aluSrc2_mux, ctl_rfWriteData_mux, ctl_rfWriteAddr_mux});
    end
    checks++; if ({ctl_rf_wen, ctl_dataRam_en, ctl_low_wen, ctl_temp_wen} !== 4'b1000) begin
      errors++; $display("FAIL addu_en: got %b want 1000", {ctl_rf_wen, ctl_dataRam_en, ctl_low_wen, ctl_temp_wen});
    end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL addu_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_mult_mflo();
    int stalls;
    drive(1'b1, I_MULT, 32'h140);
    tick();
    checks++; if ({ctl_low_wen, ctl_high_wen, ctl_rf_wen} !== 3'b110) begin
      errors++; $display("FAIL mult_en: got %b want 110", {ctl_low_wen, ctl_high_wen, ctl_rf_wen});
    end
    drive(1'b1, I_ADDU, 32'h144);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mult_addu_ready: got %b want 1", in_ready); end
    tick();
    drive(1'b1, I_MFLO, 32'h148);
    stalls = 0;
    while (!in_ready && stalls < 20) begin
      stalls++;
      tick();
    end
    $display("txn mflo stalled %0d cycles", stalls);
    checks++; if (stalls != 5) begin errors++; $display("FAIL mflo_stall: got %0d want 5", stalls); end
    tick();
    drive(1'b0, 32'h0, 32'h0);
    checks++; if (out_valid !== 1'b1 || ctl_aluSrc2_mux !== 4'b1000 || ctl_rf_wen !== 1'b1) begin
      errors++; $display("FAIL mflo_bundle: got v=%b src2=%b wen=%b want 1 1000 1", out_valid, ctl_aluSrc2_mux, ctl_rf_wen);
    end
    tick();
  endtask

  task automatic test_busy_pass();
    int n;
    drive(1'b1, I_MULTU, 32'h180);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    tick();
    drive(1'b1, I_ADDU, 32'h184);
    checks++; if (hilo_busy !== 1'b1 || in_ready !== 1'b1) begin
      errors++; $display("FAIL busy_pass: got busy=%b ready=%b want 1 1", hilo_busy, in_ready);
    end
    tick();
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h184) begin
      errors++; $display("FAIL busy_pass_out: got v=%b pc=%h want 1 184", out_valid, out_pc);
    end
    drive(1'b1, I_DIV, 32'h188);
    n = 0;
    while (!in_ready && n < 20) begin n++; tick(); end
    tick();
    drive(1'b0, 32'h0, 32'h0);
    tick();
    n = 0;
    while (hilo_busy && n < 40) begin n++; tick(); end
    $display("txn div busy %0d cycles", n);
    checks++; if (n != 12) begin errors++; $display("FAIL div_busy: got %0d want 12", n); end
  endtask

  task automatic test_delay_slot();
    drive(1'b1, I_BEQ, 32'h200);
    tick();
    checks++; if (ctl_pcValue_mux !== 5'b01000 || ctl_temp_wen !== 1'b1 || in_delay_slot !== 1'b0) begin
      errors++; $display("FAIL beq_bundle: got pcv=%b tw=%b ds=%b want 01000 1 0", ctl_pcValue_mux, ctl_temp_wen, in_delay_slot);
    end
    drive(1'b1, I_SW, 32'h204);
    tick();
    $display("txn sw pc=%h slot=%b", out_pc, in_delay_slot);
    checks++; if ({in_delay_slot, ctl_dataRam_en, ctl_dataRam_wen, ctl_rf_wen} !== 4'b1110) begin
      errors++; $display("FAIL sw_slot: got %b want 1110", {in_delay_slot, ctl_dataRam_en, ctl_dataRam_wen, ctl_rf_wen});
    end
    drive(1'b1, I_ADDU, 32'h208);
    tick();
    checks++; if (in_delay_slot !== 1'b0) begin errors++; $display("FAIL after_slot: got %b want 0", in_delay_slot); end
    drive(1'b1, I_J, 32'h20c);
    tick();
    drive(1'b1, I_JR, 32'h210);
    tick();
    checks++; if (in_delay_slot !== 1'b1 || ctl_pcValue_mux !== 5'b00010) begin
      errors++; $display("FAIL jr_in_slot: got ds=%b pcv=%b want 1 00010", in_delay_slot, ctl_pcValue_mux);
    end
    drive(1'b1, I_ADDU, 32'h214);
    tick();
    checks++; if (in_delay_slot !== 1'b1) begin errors++; $display("FAIL slot_after_jr: got %b want 1", in_delay_slot); end
    drive(1'b0, 32'h0, 32'h0);
    tick();
  endtask

  task automatic test_flush();
    drive(1'b1, I_JAL, 32'h500);
    tick();
    checks++; if ({ctl_pcValue_mux, ctl_rfWriteData_mux, ctl_rfWriteAddr_mux, ctl_rf_wen} !== 12'b00100_100_100_1) begin
      errors++; $display("FAIL jal_bundle: got %b want 001001001001",
        {ctl_pcValue_mux, ctl_rfWriteData_mux, ctl_rfWriteAddr_mux, ctl_rf_wen});
    end
    out_ready = 1'b0;
    flush = 1'b1;
    drive(1'b1, I_LW, 32'h504);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_ready: got %b want 0", in_ready); end
    tick();
    flush = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b want 0", out_valid); end
    out_ready = 1'b1;
    #1;
    tick();
    $display("txn lw pc=%h slot=%b", out_pc, in_delay_slot);
    checks++; if ({out_valid, in_delay_slot, ctl_dataRam_en, ctl_rfWriteData_mux, ctl_rfWriteAddr_mux} !== 9'b1_0_1_010_010 || out_pc !== 32'h504) begin
      errors++; $display("FAIL lw_after_flush: got %b pc=%h want 101010010 504",
        {out_valid, in_delay_slot, ctl_dataRam_en, ctl_rfWriteData_mux, ctl_rfWriteAddr_mux}, out_pc);
    end
    drive(1'b0, 32'h0, 32'h0);
    tick();
  endtask

  task automatic test_reserved();
    drive(1'b1, I_RSV, 32'h600);
    tick();
    checks++; if ({out_valid, exc_ri, ctl_rf_wen, ctl_dataRam_en, ctl_pcValue_mux} !== 9'b1_1_0_0_00001) begin
      errors++; $display("FAIL rsv_op: got %b want 110000001", {out_valid, exc_ri, ctl_rf_wen, ctl_dataRam_en, ctl_pcValue_mux});
    end
    checks++; if (exc_ri_n !== 1'b0) begin errors++; $display("FAIL rsv_noexc: got %b want 0", exc_ri_n); end
    drive(1'b1, I_RSVF, 32'h604);
    tick();
    checks++; if (exc_ri !== 1'b1 || ctl_rf_wen !== 1'b0) begin
      errors++; $display("FAIL rsv_funct: got exc=%b wen=%b want 1 0", exc_ri, ctl_rf_wen);
    end
    drive(1'b1, I_ADDU, 32'h608);
    tick();
    checks++; if (exc_ri !== 1'b0) begin errors++; $display("FAIL rsv_clear: got %b want 0", exc_ri); end
    drive(1'b0, 32'h0, 32'h0);
    tick();
  endtask

  task automatic test_stall_reset();
    drive(1'b1, I_MULT, 32'h300);
    tick();
    drive(1'b1, I_BEQ, 32'h304);
    tick();
    out_ready = 1'b0;
    drive(1'b1, I_LW, 32'h308);
    for (int i = 0; i < 3; i++) begin
      checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_pc !== 32'h304 || ctl_temp_wen !== 1'b1) begin
        errors++; $display("FAIL hold_%0d: got rdy=%b v=%b pc=%h tw=%b want 0 1 304 1", i, in_ready, out_valid, out_pc, ctl_temp_wen);
      end
      tick();
    end
    checks++; if (hilo_busy !== 1'b1) begin errors++; $display("FAIL hold_busy: got %b want 1", hilo_busy); end
    resetn = 1'b0;
    #1;
    checks++; if ({out_valid, hilo_busy, in_delay_slot, ctl_temp_wen, ctl_pcValue_mux} !== 9'h0 || out_pc !== 32'h0) begin
      errors++; $display("FAIL async_rst: got %b pc=%h want 0 0",
        {out_valid, hilo_busy, in_delay_slot, ctl_temp_wen, ctl_pcValue_mux}, out_pc);
    end
    in_valid = 1'b0;
    #1 resetn = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, I_ADDU, 32'h400);
    tick();
    checks++; if (out_valid !== 1'b1 || in_delay_slot !== 1'b0) begin
      errors++; $display("FAIL post_rst_seq: got v=%b ds=%b want 1 0", out_valid, in_delay_slot);
    end
    drive(1'b0, 32'h0, 32'h0);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_addu();
    test_mult_mflo();
    test_busy_pass();
    test_delay_slot();
    test_flush();
    test_reserved();
    test_stall_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
